// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WB and
// drives datapath selects/enables; memory uses req/ack with a bus timeout.
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_instr,
   input  logic        i_mem_ack,
   input  logic        i_br_eq,
   input  logic        i_br_lt,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic        o_addr_sel,
   output logic        o_ir_we,
   output logic        o_pc_we,
   output logic        o_pc_sel,
   output logic        o_br_un,
   output logic [1:0]  o_opa_sel,
   output logic        o_opb_sel,
   output logic [3:0]  o_alu_op,
   output logic        o_rd_wren,
   output logic [1:0]  o_wb_sel,
   output logic        o_trap,
   output logic        o_bus_err,
   output logic [2:0]  o_state
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXECUTE = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_TRAP    = 3'd5
   } state_t;

   localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(MEM_TIMEOUT - 1);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   state_t        r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic          r_bus_err;

   logic [6:0] w_opcode, w_f7;
   logic [2:0] w_f3;
   logic       w_is_r, w_is_i, w_is_lui, w_is_auipc, w_is_load, w_is_store;
   logic       w_is_br, w_is_jal, w_is_jalr, w_legal, w_rd_nz, w_taken;
   logic       w_mem_phase, w_timeout;
   logic [1:0] w_opa_sel;
   logic       w_opb_sel;
   logic [3:0] w_alu_op;
   logic       w_unused;

   assign w_opcode   = i_instr[6:0];
   assign w_f3       = i_instr[14:12];
   assign w_f7       = i_instr[31:25];
   assign w_rd_nz    = |i_instr[11:7];
   assign w_unused   = &{1'b0, i_instr[24:15]};

   assign w_is_r     = (w_opcode == OP_R);
   assign w_is_i     = (w_opcode == OP_I);
   assign w_is_lui   = (w_opcode == OP_LUI);
   assign w_is_auipc = (w_opcode == OP_AUIPC);
   assign w_is_load  = (w_opcode == OP_LOAD);
   assign w_is_store = (w_opcode == OP_STORE);
   assign w_is_br    = (w_opcode == OP_BR);
   assign w_is_jal   = (w_opcode == OP_JAL);
   assign w_is_jalr  = (w_opcode == OP_JALR);

   always_comb begin
      w_legal = 1'b0;
      if (w_is_r)
         w_legal = (w_f7 == 7'h00) ||
                   ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
      else if (w_is_i)
         w_legal = ((w_f3 != 3'b001) && (w_f3 != 3'b101)) ||
                   (w_f7 == 7'h00) || (w_f7 == 7'h20);
      else if (w_is_load)
         w_legal = (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111);
      else if (w_is_store)
         w_legal = (w_f3 <= 3'b010);
      else if (w_is_br)
         w_legal = (w_f3[2:1] != 2'b01);
      else if (w_is_jalr)
         w_legal = (w_f3 == 3'b000);
      else
         w_legal = w_is_lui || w_is_auipc || w_is_jal;
   end

   // Operand/op selection is a pure function of the held instruction, so
   // MEM and WB see the same ALU controls as EXECUTE.
   always_comb begin
      w_opa_sel = 2'b00;
      w_opb_sel = ~w_is_r;
      w_alu_op  = 4'd0;
      if (w_is_lui)
         w_opa_sel = 2'b10;
      else if (w_is_auipc || w_is_br || w_is_jal)
         w_opa_sel = 2'b01;
      if (w_is_r || w_is_i) begin
         case (w_f3)
            3'b000:  w_alu_op = (w_is_r && w_f7[5]) ? 4'd1 : 4'd0;
            3'b001:  w_alu_op = 4'd7;
            3'b010:  w_alu_op = 4'd2;
            3'b011:  w_alu_op = 4'd3;
            3'b100:  w_alu_op = 4'd4;
            3'b101:  w_alu_op = w_f7[5] ? 4'd9 : 4'd8;
            3'b110:  w_alu_op = 4'd5;
            default: w_alu_op = 4'd6;
         endcase
      end
   end

   // funct3[0] inverts the sense: BNE/BGE/BGEU are the complements.
   assign w_taken = w_f3[2] ? (i_br_lt ^ w_f3[0]) : (i_br_eq ^ w_f3[0]);

   assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEM);
   assign w_timeout   = w_mem_phase && !i_mem_ack && (r_cnt == CNT_MAX);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= S_FETCH;
         r_cnt     <= '0;
         r_bus_err <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_mem_phase && !i_mem_ack && (w_next == r_state))
            r_cnt <= r_cnt + 1'b1;
         else
            r_cnt <= '0;
         if (w_timeout)
            r_bus_err <= 1'b1;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH: begin
            if (i_mem_ack)      w_next = S_DECODE;
            else if (w_timeout) w_next = S_TRAP;
         end
         S_DECODE:
            w_next = w_legal ? S_EXECUTE : S_TRAP;
         S_EXECUTE: begin
            if (w_is_r || w_is_i || w_is_lui || w_is_auipc) w_next = S_WB;
            else if (w_is_load || w_is_store)               w_next = S_MEM;
            else if (w_is_br || w_is_jal || w_is_jalr)      w_next = S_FETCH;
            else                                            w_next = S_TRAP;
         end
         S_MEM: begin
            if (i_mem_ack)      w_next = w_is_load ? S_WB : S_FETCH;
            else if (w_timeout) w_next = S_TRAP;
         end
         S_WB:    w_next = S_FETCH;
         S_TRAP:  w_next = S_TRAP;
         default: w_next = S_TRAP;
      endcase
   end

   always_comb begin
      o_mem_req  = 1'b0;
      o_mem_we   = 1'b0;
      o_addr_sel = 1'b0;
      o_ir_we    = 1'b0;
      o_pc_we    = 1'b0;
      o_pc_sel   = 1'b0;
      o_br_un    = 1'b0;
      o_opa_sel  = 2'b00;
      o_opb_sel  = 1'b0;
      o_alu_op   = 4'd0;
      o_rd_wren  = 1'b0;
      o_wb_sel   = 2'b00;
      o_trap     = 1'b0;
      o_bus_err  = 1'b0;
      o_state    = 3'd0;
      if (!i_reset) begin
         o_state   = r_state;
         o_bus_err = r_bus_err;
         case (r_state)
            S_FETCH: begin
               o_mem_req = 1'b1;
               o_ir_we   = i_mem_ack;
            end
            S_EXECUTE: begin
               o_opa_sel = w_opa_sel;
               o_opb_sel = w_opb_sel;
               o_alu_op  = w_alu_op;
               if (w_is_br) begin
                  o_br_un  = w_f3[1];
                  o_pc_we  = 1'b1;
                  o_pc_sel = w_taken;
               end
               if (w_is_jal || w_is_jalr) begin
                  o_pc_we   = 1'b1;
                  o_pc_sel  = 1'b1;
                  o_rd_wren = w_rd_nz;
                  o_wb_sel  = 2'b10;
               end
            end
            S_MEM: begin
               o_opa_sel  = w_opa_sel;
               o_opb_sel  = w_opb_sel;
               o_alu_op   = w_alu_op;
               o_mem_req  = 1'b1;
               o_addr_sel = 1'b1;
               o_mem_we   = w_is_store;
               o_pc_we    = w_is_store && i_mem_ack;
               o_wb_sel   = w_is_load ? 2'b01 : 2'b00;
            end
            S_WB: begin
               o_opa_sel = w_opa_sel;
               o_opb_sel = w_opb_sel;
               o_alu_op  = w_alu_op;
               o_rd_wren = w_rd_nz;
               o_pc_we   = 1'b1;
               o_wb_sel  = w_is_load ? 2'b01 : 2'b00;
            end
            S_TRAP:  o_trap = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: scripted instruction flows push expected per-cycle
// output fields to a queue; a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        i_reset = 1'b1;
   logic [31:0] i_instr = 32'h0;
   logic        i_mem_ack = 1'b0;
   logic        i_br_eq = 1'b0;
   logic        i_br_lt = 1'b0;
   logic        o_mem_req, o_mem_we, o_addr_sel, o_ir_we, o_pc_we, o_pc_sel, o_br_un;
   logic [1:0]  o_opa_sel;
   logic        o_opb_sel;
   logic [3:0]  o_alu_op;
   logic        o_rd_wren;
   logic [1:0]  o_wb_sel;
   logic        o_trap, o_bus_err;
   logic [2:0]  o_state;

   multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_instr(i_instr), .i_mem_ack(i_mem_ack),
      .i_br_eq(i_br_eq), .i_br_lt(i_br_lt), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
      .o_addr_sel(o_addr_sel), .o_ir_we(o_ir_we), .o_pc_we(o_pc_we), .o_pc_sel(o_pc_sel),
      .o_br_un(o_br_un), .o_opa_sel(o_opa_sel), .o_opb_sel(o_opb_sel), .o_alu_op(o_alu_op),
      .o_rd_wren(o_rd_wren), .o_wb_sel(o_wb_sel), .o_trap(o_trap), .o_bus_err(o_bus_err),
      .o_state(o_state)
   );

   always #5 clk = ~clk;

   // Output vector layout (LSB first): state[2:0] bus_err trap wb[6:5] rd_wren
   // alu[11:8] opb opa[14:13] br_un pc_sel pc_we ir_we addr_sel mem_we mem_req
   localparam int F_STATE = 0, F_BERR = 3, F_TRAP = 4, F_WB = 5, F_RDW = 7, F_ALU = 8;
   localparam int F_OPB = 12, F_OPA = 13, F_BRUN = 15, F_PCSEL = 16, F_PCWE = 17;
   localparam int F_IRWE = 18, F_ADDR = 19, F_MWE = 20, F_MREQ = 21;
   int    f_lsb[15]  = '{0, 3, 4, 5, 7, 8, 12, 13, 15, 16, 17, 18, 19, 20, 21};
   int    f_w[15]    = '{3, 1, 1, 2, 1, 4, 1, 2, 1, 1, 1, 1, 1, 1, 1};
   string f_name[15] = '{"state", "bus_err", "trap", "wb_sel", "rd_wren", "alu_op",
                         "opb_sel", "opa_sel", "br_un", "pc_sel", "pc_we", "ir_we",
                         "addr_sel", "mem_we", "mem_req"};

   logic [21:0] w_obs;
   assign w_obs = {o_mem_req, o_mem_we, o_addr_sel, o_ir_we, o_pc_we, o_pc_sel, o_br_un,
                   o_opa_sel, o_opb_sel, o_alu_op, o_rd_wren, o_wb_sel, o_trap, o_bus_err,
                   o_state};

   logic [43:0] exp_q[$];
   logic [21:0] e_m, e_v;
   int          n_total = 0;
   int          n_bad = 0;
   string       cur_test = "reset";

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Monitor: one expected entry per cycle, compared away from the active edge.
   logic [43:0] m_e;
   logic [31:0] m_obs, m_exp;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         m_e = exp_q.pop_front();
         for (int f = 0; f < 15; f++) begin
            if (m_e[22 + f_lsb[f]]) begin
               m_obs = '0;
               m_exp = '0;
               for (int k = 0; k < f_w[f]; k++) begin
                  m_obs[k] = w_obs[f_lsb[f] + k];
                  m_exp[k] = m_e[f_lsb[f] + k];
               end
               check_eq({cur_test, ".", f_name[f]}, m_obs, m_exp);
            end
         end
      end
   end

   task automatic x_clr();
      e_m = '0;
      e_v = '0;
   endtask

   task automatic ex(input int lsb, input int w, input logic [3:0] val);
      for (int k = 0; k < w; k++) begin
         e_m[lsb + k] = 1'b1;
         e_v[lsb + k] = val[k];
      end
   endtask

   task automatic cyc(input logic ack, input logic lt, input logic eq);
      i_mem_ack = ack;
      i_br_lt   = lt;
      i_br_eq   = eq;
      exp_q.push_back({e_m, e_v});
      @(posedge clk);
      #1;
      i_mem_ack = 1'b0;
   endtask

   task automatic do_reset(input int n);
      i_reset = 1'b1;
      for (int i = 0; i < n; i++) begin
         e_m = '1;
         e_v = '0;
         cyc(1'b0, 1'b0, 1'b0);
      end
      i_reset = 1'b0;
   endtask

   task automatic c_fetch(input logic ack);
      x_clr();
      ex(F_STATE, 3, 0); ex(F_MREQ, 1, 1); ex(F_MWE, 1, 0); ex(F_ADDR, 1, 0);
      ex(F_IRWE, 1, ack); ex(F_PCWE, 1, 0); ex(F_RDW, 1, 0); ex(F_TRAP, 1, 0);
      cyc(ack, 1'b0, 1'b0);
   endtask

   task automatic fetch(input logic [31:0] instr, input int waits);
      i_instr = instr;
      for (int i = 0; i < waits; i++) c_fetch(1'b0);
      c_fetch(1'b1);
   endtask

   task automatic c_decode();
      x_clr();
      ex(F_STATE, 3, 1); ex(F_MREQ, 1, 0); ex(F_IRWE, 1, 0); ex(F_PCWE, 1, 0);
      ex(F_RDW, 1, 0); ex(F_TRAP, 1, 0);
      cyc(1'b0, 1'b0, 1'b0);
   endtask

   task automatic c_alu(input logic [1:0] opa, input logic opb, input logic [3:0] alu);
      x_clr();
      ex(F_STATE, 3, 2); ex(F_OPA, 2, opa); ex(F_OPB, 1, opb); ex(F_ALU, 4, alu);
      ex(F_MREQ, 1, 0); ex(F_PCWE, 1, 0); ex(F_RDW, 1, 0); ex(F_IRWE, 1, 0);
      cyc(1'b0, 1'b0, 1'b0);
   endtask

   task automatic c_wb(input logic rdw, input logic [1:0] wb);
      x_clr();
      ex(F_STATE, 3, 4); ex(F_RDW, 1, rdw); ex(F_PCWE, 1, 1); ex(F_PCSEL, 1, 0);
      ex(F_WB, 2, wb); ex(F_MREQ, 1, 0);
      cyc(1'b0, 1'b0, 1'b0);
   endtask

   task automatic c_branch(input logic brun, input logic lt, input logic eq, input logic taken);
      x_clr();
      ex(F_STATE, 3, 2); ex(F_OPA, 2, 1); ex(F_OPB, 1, 1); ex(F_ALU, 4, 0);
      ex(F_BRUN, 1, brun); ex(F_PCWE, 1, 1); ex(F_PCSEL, 1, taken); ex(F_RDW, 1, 0);
      ex(F_MREQ, 1, 0);
      cyc(1'b0, lt, eq);
   endtask

   task automatic c_jump(input logic [1:0] opa, input logic rdw);
      x_clr();
      ex(F_STATE, 3, 2); ex(F_OPA, 2, opa); ex(F_OPB, 1, 1); ex(F_ALU, 4, 0);
      ex(F_PCWE, 1, 1); ex(F_PCSEL, 1, 1); ex(F_RDW, 1, rdw); ex(F_WB, 2, 2);
      cyc(1'b0, 1'b0, 1'b0);
   endtask

   task automatic c_mem(input logic store, input logic ack);
      x_clr();
      ex(F_STATE, 3, 3); ex(F_MREQ, 1, 1); ex(F_ADDR, 1, 1); ex(F_MWE, 1, store);
      ex(F_OPA, 2, 0); ex(F_OPB, 1, 1); ex(F_ALU, 4, 0); ex(F_PCWE, 1, store & ack);
      ex(F_RDW, 1, 0); ex(F_IRWE, 1, 0);
      if (store && ack) ex(F_PCSEL, 1, 0);
      cyc(ack, 1'b0, 1'b0);
   endtask

   task automatic c_trap(input logic berr, input logic ack);
      x_clr();
      ex(F_STATE, 3, 5); ex(F_TRAP, 1, 1); ex(F_BERR, 1, berr); ex(F_MREQ, 1, 0);
      ex(F_IRWE, 1, 0); ex(F_PCWE, 1, 0); ex(F_RDW, 1, 0); ex(F_MWE, 1, 0);
      cyc(ack, 1'b0, 1'b0);
   endtask

   function automatic logic [3:0] r_alu(input logic [2:0] f3, input logic alt);
      case (f3)
         3'd0: return alt ? 4'd1 : 4'd0;
         3'd1: return 4'd7;
         3'd2: return 4'd2;
         3'd3: return 4'd3;
         3'd4: return 4'd4;
         3'd5: return alt ? 4'd9 : 4'd8;
         3'd6: return 4'd5;
         default: return 4'd6;
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  br_f3s[6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      logic [2:0]  f3;
      logic        lt, eq, tk, alt;
      logic [4:0]  rd;
      @(posedge clk);
      #1;
      do_reset(2);

      cur_test = "add";
      fetch(32'h002081B3, 2);
      c_decode(); c_alu(2'b00, 1'b0, 4'd0); c_wb(1'b1, 2'b00);

      cur_test = "sub";
      fetch(32'h402081B3, 0);
      c_decode(); c_alu(2'b00, 1'b0, 4'd1); c_wb(1'b1, 2'b00);

      cur_test = "srai";
      fetch(32'h4020D193, 1);
      c_decode(); c_alu(2'b00, 1'b1, 4'd9); c_wb(1'b1, 2'b00);

      cur_test = "add_x0";
      fetch(32'h00208033, 0);
      c_decode(); c_alu(2'b00, 1'b0, 4'd0); c_wb(1'b0, 2'b00);

      cur_test = "lui";
      fetch(32'h123451B7, 0);
      c_decode(); c_alu(2'b10, 1'b1, 4'd0); c_wb(1'b1, 2'b00);

      cur_test = "auipc";
      fetch(32'h12345197, 0);
      c_decode(); c_alu(2'b01, 1'b1, 4'd0); c_wb(1'b1, 2'b00);

      cur_test = "bgeu_taken";
      fetch(32'h0020F463, 0);
      c_decode(); c_branch(1'b1, 1'b0, 1'b0, 1'b1);
      cur_test = "bgeu_not";
      fetch(32'h0020F463, 0);
      c_decode(); c_branch(1'b1, 1'b1, 1'b0, 1'b0);

      cur_test = "br_rand";
      for (int i = 0; i < 10; i++) begin
         f3 = br_f3s[$urandom_range(0, 5)];
         lt = 1'($urandom_range(0, 1));
         eq = 1'($urandom_range(0, 1));
         case (f3)
            3'd0:       tk = eq;
            3'd1:       tk = !eq;
            3'd4, 3'd6: tk = lt;
            default:    tk = !lt;
         endcase
         fetch({7'h00, 5'd2, 5'd1, f3, 5'd8, 7'b1100011}, 0);
         c_decode(); c_branch(f3[1], lt, eq, tk);
      end

      cur_test = "r_rand";
      for (int i = 0; i < 10; i++) begin
         f3  = 3'($urandom_range(0, 7));
         alt = ((f3 == 3'd0) || (f3 == 3'd5)) ? 1'($urandom_range(0, 1)) : 1'b0;
         rd  = 5'($urandom_range(1, 31));
         fetch({1'b0, alt, 5'd0, 5'd2, 5'd1, f3, rd, 7'b0110011}, $urandom_range(0, 3));
         c_decode(); c_alu(2'b00, 1'b0, r_alu(f3, alt)); c_wb(1'b1, 2'b00);
      end

      cur_test = "jal";
      fetch(32'h008000EF, 0);
      c_decode(); c_jump(2'b01, 1'b1);
      cur_test = "jalr_x0";
      fetch(32'h00008067, 0);
      c_decode(); c_jump(2'b00, 1'b0);

      cur_test = "lw";
      fetch(32'h0000A183, 0);
      c_decode(); c_alu(2'b00, 1'b1, 4'd0);
      for (int i = 0; i < 5; i++) c_mem(1'b0, 1'b0);
      c_mem(1'b0, 1'b1);
      c_wb(1'b1, 2'b01);

      cur_test = "sw";
      fetch(32'h0020A023, 0);
      c_decode(); c_alu(2'b00, 1'b1, 4'd0);
      c_mem(1'b1, 1'b0); c_mem(1'b1, 1'b1);
      cur_test = "after_sw";
      c_fetch(1'b0);

      cur_test = "sw_timeout";
      fetch(32'h0020A023, 0);
      c_decode(); c_alu(2'b00, 1'b1, 4'd0);
      for (int i = 0; i < 16; i++) c_mem(1'b1, 1'b0);
      c_trap(1'b1, 1'b0); c_trap(1'b1, 1'b0);
      do_reset(1);

      cur_test = "fetch_timeout";
      for (int i = 0; i < 16; i++) c_fetch(1'b0);
      c_trap(1'b1, 1'b0);
      do_reset(1);

      cur_test = "reset_mid";
      for (int i = 0; i < 10; i++) c_fetch(1'b0);
      do_reset(1);
      fetch(32'h002081B3, 15);
      c_decode(); c_alu(2'b00, 1'b0, 4'd0); c_wb(1'b1, 2'b00);

      cur_test = "illegal_op";
      fetch(32'h00000000, 0);
      c_decode(); c_trap(1'b0, 1'b0); c_trap(1'b0, 1'b1); c_trap(1'b0, 1'b0);
      do_reset(1);
      cur_test = "post_trap";
      c_fetch(1'b0);

      cur_test = "illegal_br";
      fetch(32'h0020A463, 0);
      c_decode(); c_trap(1'b0, 1'b0);
      do_reset(1);
      cur_test = "illegal_r";
      fetch(32'h402091B3, 0);
      c_decode(); c_trap(1'b0, 1'b0);
      do_reset(1);

      cur_test = "end";
      c_fetch(1'b0);
      check_eq("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
